ifu_ift2itcm: RTL and testbench

Instruction-fetch memory bridge between the fetch stage's request/response port and the single-port ITCM SRAM. It accepts fetch PCs, decodes the address window and drives the SRAM with 1-cycle read latency. Returned words go to fetch via a same-cycle bypass or a 2-entry response buffer. Out-of-window or misaligned PCs get an error response carrying a NOP, and a flush discards everything in flight.

---
 rtl/ifu_ift2itcm.sv | 162 ++++++++++++++++
 tb/tb_ifu_ift2itcm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_ift2itcm.sv
// ifu_ift2itcm
// Bridge between the fetch stage's request/response port and the single-port
// ITCM SRAM.
//
// The ITCM window is decoded combinationally, and accepted in-window PCs drive
// the SRAM in the same cycle. The read data returns one cycle later. It goes
// straight to fetch when nothing older is buffered; otherwise, or when fetch
// stalls, it is parked in a 2-entry FIFO. PCs that are outside the window or
// misaligned never touch the SRAM. They return an error response with a NOP.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifu_req_valid/ready/pc      fetch request handshake and address
//   ifu_rsp_valid/ready         fetch response handshake
//   ifu_rsp_instr, ifu_rsp_err  returned word (NOP on error) and error flag
//   ifu_flush                   drop everything in flight and buffered
//   itcm_busy                   SRAM port granted elsewhere this cycle
//   itcm_cs, itcm_addr          SRAM read strobe and word address
//   itcm_rdata                  SRAM data, valid the cycle after itcm_cs
module ifu_ift2itcm #(
    parameter int                PC_SIZE    = 32,
    parameter int                INSTR_SIZE = 32,
    parameter int                ITCM_AW    = 14,
    parameter logic [PC_SIZE-1:0] ITCM_BASE = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_rsp_err,
    input  logic                  ifu_flush,
    input  logic                  itcm_busy,
    output logic                  itcm_cs,
    output logic [ITCM_AW-1:0]    itcm_addr,
    input  logic [INSTR_SIZE-1:0] itcm_rdata
);

    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = INSTR_SIZE'(32'h0000_0013);

    logic                  inflight_q, inflight_d;
    logic                  inflight_err_q, inflight_err_d;
    logic                  inflight_kill_q, inflight_kill_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ITCM_AW-1:0]    addr_q, addr_d;
    logic                  fifo_err_q   [2];
    logic                  fifo_err_d   [2];
    logic [INSTR_SIZE-1:0] fifo_instr_q [2];
    logic [INSTR_SIZE-1:0] fifo_instr_d [2];

    logic                  req_hsk;
    logic                  req_err;
    logic                  fifo_nonempty;
    logic                  ret_visible;
    logic                  ret_live;
    logic [INSTR_SIZE-1:0] ret_data;
    logic                  rsp_pop;
    logic                  fifo_pop;
    logic                  push;

    // The occupancy limit counts the outstanding SRAM read. Every accepted
    // request is therefore guaranteed a FIFO slot, even if fetch stalls
    // indefinitely. The limit depends only on registered state, so there is
    // no combinational path from ifu_rsp_ready to ifu_req_ready.
    always_comb begin
        ifu_req_ready = ~ifu_flush & ~itcm_busy &
                        (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
        req_hsk       = ifu_req_valid & ifu_req_ready;
        req_err       = (ifu_req_pc[PC_SIZE-1:ITCM_AW+2] != ITCM_BASE[PC_SIZE-1:ITCM_AW+2])
                        | (ifu_req_pc[1:0] != 2'b00);
        itcm_cs       = req_hsk & ~req_err;
        itcm_addr     = itcm_cs ? ifu_req_pc[ITCM_AW+1:2] : addr_q;
        addr_d        = itcm_addr;
    end

    // A return that coincides with a flush is dropped here. Later returns
    // are dropped through inflight_kill_q.
    always_comb begin
        fifo_nonempty = (count_q != 2'd0);
        ret_visible   = inflight_q & ~inflight_kill_q;
        ret_live      = ret_visible & ~ifu_flush;
        ret_data      = inflight_err_q ? NOP_INSTR : itcm_rdata;

        ifu_rsp_valid = ~ifu_flush & (fifo_nonempty | ret_visible);
        if (fifo_nonempty) begin
            ifu_rsp_instr = fifo_instr_q[rd_ptr_q];
            ifu_rsp_err   = fifo_err_q[rd_ptr_q];
        end else if (ret_visible) begin
            ifu_rsp_instr = ret_data;
            ifu_rsp_err   = inflight_err_q;
        end else begin
            ifu_rsp_instr = '0;
            ifu_rsp_err   = 1'b0;
        end

        rsp_pop  = ifu_rsp_valid & ifu_rsp_ready;
        fifo_pop = rsp_pop & fifo_nonempty;
        // If the return was consumed through the bypass, it is not stored.
        push     = ret_live & ~(rsp_pop & ~fifo_nonempty);
    end

    always_comb begin
        inflight_d      = req_hsk;
        inflight_err_d  = req_err;
        // Requests are blocked while flushing. Anything recorded during a
        // flush cycle is marked dead so that it can never surface.
        inflight_kill_d = ifu_flush;

        if (ifu_flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, fifo_pop};
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ fifo_pop;
        end

        for (int i = 0; i < 2; i++) begin
            fifo_err_d[i]   = fifo_err_q[i];
            fifo_instr_d[i] = fifo_instr_q[i];
            if (push && (wr_ptr_q == 1'(i))) begin
                fifo_err_d[i]   = inflight_err_q;
                fifo_instr_d[i] = ret_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_err_q  <= 1'b0;
            inflight_kill_q <= 1'b0;
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            addr_q          <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_err_q[i]   <= 1'b0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            inflight_q      <= inflight_d;
            inflight_err_q  <= inflight_err_d;
            inflight_kill_q <= inflight_kill_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            addr_q          <= addr_d;
            for (int i = 0; i < 2; i++) begin
                fifo_err_q[i]   <= fifo_err_d[i];
                fifo_instr_q[i] <= fifo_instr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ifu_ift2itcm.sv
// Testbench for ifu_ift2itcm.
// It drives a table of fetch PCs, then runs hand-written sequences for
// backpressure, flush, busy and reset.
// A negedge monitor pushes expected responses on each request handshake and
// pops and compares them on each response handshake.
module tb_ifu_ift2itcm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        ifu_flush;
    logic        itcm_busy;
    logic        itcm_cs;
    logic [13:0] itcm_addr;
    logic [31:0] itcm_rdata;

    ifu_ift2itcm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_rsp_err   (ifu_rsp_err),
        .ifu_flush     (ifu_flush),
        .itcm_busy     (itcm_busy),
        .itcm_cs       (itcm_cs),
        .itcm_addr     (itcm_addr),
        .itcm_rdata    (itcm_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model with a 1-cycle read latency.
    // Word 4 holds 0x93; every other word holds 0x1000_0000 | address.
    function automatic logic [31:0] sram_word(input logic [13:0] a);
        return (a == 14'd4) ? 32'h0000_0093 : (32'h1000_0000 | {18'b0, a});
    endfunction

    logic [13:0] rd_addr = 14'd0;
    always @(posedge clk) if (itcm_cs) rd_addr <= itcm_addr;
    assign itcm_rdata = sram_word(rd_addr);

    typedef struct {
        logic [31:0] pc;
        logic        err;
        logic [31:0] instr;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    logic        cur_exp_err   = 1'b0;
    logic [31:0] cur_exp_instr = 32'h0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor. It samples mid-cycle, while the inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else if (ifu_flush) begin
            check("flush_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
            check("flush_req_ready", 32'(ifu_req_ready), 32'd0);
            sb_q.delete();
        end else begin
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(ifu_rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_err", 32'(ifu_rsp_err), 32'(e.err));
                    check("rsp_instr", ifu_rsp_instr, e.instr);
                    $display("rsp: instr=%h err=%0d", ifu_rsp_instr, ifu_rsp_err);
                end
            end
            if (ifu_req_valid && ifu_req_ready) begin
                check("req_cs", 32'(itcm_cs), 32'(!cur_exp_err));
                if (!cur_exp_err) check("req_addr", 32'(itcm_addr), 32'(ifu_req_pc[15:2]));
                sb_q.push_back('{cur_exp_err, cur_exp_instr});
                $display("req: pc=%h exp_err=%0d exp_instr=%h", ifu_req_pc, cur_exp_err, cur_exp_instr);
            end else begin
                check("cs_idle", 32'(itcm_cs), 32'd0);
            end
        end
    end

    // Presents one request and waits until it is accepted.
    // waited returns the number of cycles spent stalled.
    task automatic issue(input vec_t v, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        cur_exp_err   = v.err;
        cur_exp_instr = v.instr;
        ifu_req_pc    = v.pc;
        ifu_req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ifu_req_ready;
            if (!ok) waited++;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        ifu_req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[8];
    int   w;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h8000_0000, 1'b0, 32'h1000_0000};
        vecs[1] = '{32'h8000_0004, 1'b0, 32'h1000_0001};
        vecs[2] = '{32'h8000_0008, 1'b0, 32'h1000_0002};
        vecs[3] = '{32'h8000_0010, 1'b0, 32'h0000_0093};
        vecs[4] = '{32'h0000_1000, 1'b1, 32'h0000_0013};
        vecs[5] = '{32'h8000_0002, 1'b1, 32'h0000_0013};
        vecs[6] = '{32'h8000_FFFC, 1'b0, 32'h1000_3FFF};
        vecs[7] = '{32'h8001_0000, 1'b1, 32'h0000_0013};

        ifu_req_valid = 1'b0;
        ifu_req_pc    = 32'h0;
        ifu_rsp_ready = 1'b1;
        ifu_flush     = 1'b0;
        itcm_busy     = 1'b0;

        // Reset values.
        #12;
        check("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(ifu_rsp_err), 32'd0);
        check("rst_rsp_instr", ifu_rsp_instr, 32'd0);
        check("rst_cs", 32'(itcm_cs), 32'd0);
        check("rst_addr", 32'(itcm_addr), 32'd0);
        check("rst_req_ready", 32'(ifu_req_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Table: back-to-back requests with no backpressure.
        // Every request must be accepted without a stall.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i], w);
            check("b2b_no_stall", 32'(w), 32'd0);
        end
        idle(3);
        check("b2b_drained", 32'(sb_q.size()), 32'd0);

        // Single fetch: the response must be valid in the next cycle.
        issue(vecs[3], w);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(ifu_rsp_valid), 32'd1);
        check("latency_instr", ifu_rsp_instr, 32'h0000_0093);
        @(posedge clk);
        #1;
        idle(2);

        // Backpressure: two requests are accepted, the third stalls.
        ifu_rsp_ready = 1'b0;
        issue(vecs[0], w);
        check("bp_first", 32'(w), 32'd0);
        issue(vecs[1], w);
        check("bp_second", 32'(w), 32'd0);
        cur_exp_err   = vecs[2].err;
        cur_exp_instr = vecs[2].instr;
        ifu_req_pc    = vecs[2].pc;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 32'(ifu_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        ifu_rsp_ready = 1'b1;
        issue(vecs[2], w);
        check("bp_release_wait", 32'(w), 32'd1);
        idle(4);
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Flush with one buffered response and one read in flight.
        ifu_rsp_ready = 1'b0;
        issue(vecs[0], w);
        issue(vecs[1], w);
        ifu_flush     = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = vecs[2].pc;
        @(posedge clk);
        #1;
        ifu_flush     = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_flush_valid", 32'(ifu_rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // While busy, nothing is accepted; acceptance happens the cycle busy drops.
        itcm_busy     = 1'b1;
        ifu_req_valid = 1'b1;
        cur_exp_err   = vecs[1].err;
        cur_exp_instr = vecs[1].instr;
        ifu_req_pc    = vecs[1].pc;
        repeat (3) begin
            @(negedge clk);
            check("busy_ready_low", 32'(ifu_req_ready), 32'd0);
            check("busy_cs_low", 32'(itcm_cs), 32'd0);
            @(posedge clk);
            #1;
        end
        itcm_busy = 1'b0;
        issue(vecs[1], w);
        check("busy_release_wait", 32'(w), 32'd0);
        idle(3);
        check("busy_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-operation loses the pending response.
        ifu_rsp_ready = 1'b0;
        issue(vecs[6], w);
        ifu_req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifu_rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ifu_rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 32'(ifu_rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
